phase_timer_scheduler: RTL and testbench
========================================

# phase_timer_scheduler

Programmable interval timer and parameter store for the traffic light controller. It holds the three field-programmable phase durations: base green, extended green and yellow. It accepts reprogram requests from the operator inputs and runs one countdown at a time on behalf of the light-sequencing FSM. Completion is reported with a single-cycle `expired` pulse. The block sits between the top-level operator inputs and the phase FSM, and it is the only owner of the shared seconds counter.

## Interface
- `CLK_DIV`, 4: clock cycles per one-second tick; legal range 2–65535.
- `DEF_BASE`, 6: reset value of the base-green duration, in seconds.
- `DEF_EXT`, 3: reset value of the extended-green duration, in seconds.
- `DEF_YEL`, 2: reset value of the yellow duration, in seconds.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reprogram`  in  1  one-cycle strobe that writes `time_value` into the register chosen by `time_param_selector`.
- `time_param_selector`  in  2  register select: 0 = base, 1 = extended, 2 = yellow, 3 = restore all defaults.
- `time_value`  in  4  new duration in seconds.
- `start_timer`  in  1  FSM request to start a countdown.
- `interval_sel`  in  2  interval to run: 0 = base, 1 = extended, 2 = yellow, 3 = base×2.
- `busy`  out  1  high while a countdown is running.
- `expired`  out  1  one-cycle pulse when the countdown completes.
- `restart`  out  1  one-cycle pulse one cycle after an accepted reprogram; tells the FSM to return to its initial phase.
- `tick`  out  1  one-cycle seconds strobe; valid only while `busy`.

## Operation
- Parameter registers are 4 bits each. On reset they load `DEF_*`.
- `reprogram` with selector 0–2 writes `time_value` into the selected register.
  - A write of 0 is stored as 1; the minimum duration is 1 s.
- `reprogram` with selector 3 reloads all three registers with `DEF_*`, ignoring `time_value`.
- An accepted reprogram also:
  - aborts any running countdown (`busy` falls on the next cycle, and `expired` does not pulse);
  - pulses `restart`.
- Duration D is taken from the interval registers at the cycle `start_timer` is sampled.
  - Arithmetic is 5 bits wide: base×2 reaches at most 30.
  - D is frozen for the whole countdown; a later reprogram does not alter it except by aborting.
- FSM states:
  - IDLE → RUN on `start_timer`. The countdown loads with D and the prescaler clears.
  - RUN: the prescaler counts 0..`CLK_DIV`-1 and `tick` fires on terminal count. Each tick decrements the countdown. The tick that takes the countdown from 1 to 0 moves the FSM to DONE.
  - DONE: `expired` = 1 for exactly one cycle, then the FSM returns to IDLE.
    - If `start_timer` is high in DONE, the FSM goes directly to RUN with the new interval.
  - `start_timer` in RUN is a retrigger: it reloads the countdown with the new D and clears the prescaler.
- Simultaneous events:
  - `reprogram` and `start_timer` in the same cycle: reprogram wins, the start is dropped, and the FSM goes to IDLE.
  - `reprogram` while in DONE: `expired` still pulses and `restart` follows.

## Timing
- Reset values:
  - `busy`, `expired`, `restart` and `tick` are all 0.
  - The FSM is in IDLE, and the prescaler and countdown are 0.
- Start latency:
  - `busy` rises in the cycle after `start_timer` is sampled.
  - `expired` is high exactly D×`CLK_DIV`+1 cycles after that sampling edge.
- `restart` is high for the one cycle that follows the reprogram edge. Register contents are updated on that same edge.
- A reset assertion mid-countdown clears the state immediately and asynchronously, and produces no `expired` pulse.

## Configuration
- `TIMER_READBACK_EN`, when defined:
  - adds output port `remaining` (5 bits): seconds left in the current countdown, 0 when idle;
  - adds output port `param_rdata` (4 bits): the register addressed by `time_param_selector`, or 0 for selector 3.
- When `TIMER_READBACK_EN` is not defined, both ports and their logic are absent and behaviour is otherwise identical.

## Structure
- Package `timing_pkg` holds:
  - localparams for selector codes and interval codes;
  - the FSM state encoding (IDLE/RUN/DONE, 2 bits);
  - the duration width (5).
- Sub-module `sec_prescaler` is natural: a parameterized modulo-`CLK_DIV` counter with a synchronous clear and a terminal-count `tick` output. The top level holds the registers, the FSM and the countdown.

## Test plan
- Release reset, then pulse `start_timer` with `interval_sel`=0 (`CLK_DIV`=4) → `busy` high next cycle; 6 ticks; `expired` pulses 25 cycles after the start edge.
- `reprogram` with selector 2 and value 4, then start yellow → `expired` after 17 cycles.
- `reprogram` with selector 0 and value 0, then start base×2 → D=2, `expired` after 9 cycles.
- Start base, then reprogram with selector 1 and value 5 at cycle 10 → `busy` drops, no `expired`, `restart` pulses one cycle later.
- `start_timer` and `reprogram` in the same cycle → FSM stays IDLE, `restart` pulses, the register is updated.
- Retrigger at cycle 8 with yellow, then assert reset at cycle 5 of a second run → the countdown reloads to 2; reset clears all outputs to 0 immediately.

Source files
------------

// File: rtl/timing_pkg.sv
// Shared codes and types for the phase timer: selector/interval codes, FSM
// state encoding and the countdown width.
package timing_pkg;

  localparam int unsigned DurW   = 5;
  localparam int unsigned ParamW = 4;

  // time_param_selector codes
  localparam logic [1:0] SelBase     = 2'd0;
  localparam logic [1:0] SelExt      = 2'd1;
  localparam logic [1:0] SelYel      = 2'd2;
  localparam logic [1:0] SelDefaults = 2'd3;

  // interval_sel codes
  localparam logic [1:0] IntBase   = 2'd0;
  localparam logic [1:0] IntExt    = 2'd1;
  localparam logic [1:0] IntYel    = 2'd2;
  localparam logic [1:0] IntBaseX2 = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // A programmed duration of zero is stored as one second.
  function automatic logic [ParamW-1:0] min_one(input logic [ParamW-1:0] v);
    return (v == '0) ? ParamW'(1) : v;
  endfunction

endpackage

// File: rtl/phase_timer_scheduler_if.sv
// Operator/FSM-facing signal bundle of the phase timer. The master side is the
// light-sequencing FSM plus operator inputs; the slave side is the timer.
// With TIMER_READBACK_EN defined, remaining/param_rdata readback is added.
interface phase_timer_scheduler_if;

  logic       reprogram;
  logic [1:0] time_param_selector;
  logic [3:0] time_value;
  logic       start_timer;
  logic [1:0] interval_sel;
  logic       busy;
  logic       expired;
  logic       restart;
  logic       tick;
`ifdef TIMER_READBACK_EN
  logic [4:0] remaining;
  logic [3:0] param_rdata;

  modport master (
    output reprogram, time_param_selector, time_value, start_timer, interval_sel,
    input  busy, expired, restart, tick, remaining, param_rdata
  );

  modport slave (
    input  reprogram, time_param_selector, time_value, start_timer, interval_sel,
    output busy, expired, restart, tick, remaining, param_rdata
  );
`else
  modport master (
    output reprogram, time_param_selector, time_value, start_timer, interval_sel,
    input  busy, expired, restart, tick
  );

  modport slave (
    input  reprogram, time_param_selector, time_value, start_timer, interval_sel,
    output busy, expired, restart, tick
  );
`endif

endinterface

// File: rtl/sec_prescaler.sv
// Modulo-ClkDiv counter producing a one-cycle tick on terminal count.
// Synchronous clear has priority over counting.
module sec_prescaler #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned    CntW    = $clog2(ClkDiv);
  localparam logic [CntW-1:0] TermCnt = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TermCnt);

  // Next count: clear, wrap on terminal count, or increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_timer_scheduler.sv
// Phase duration store and single countdown timer for the light-sequencing FSM.
// Reprogram aborts any countdown and pulses restart; expired pulses once per
// completed countdown. Define TIMER_READBACK_EN to add remaining/param_rdata.
module phase_timer_scheduler
  import timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [3:0]  DEF_BASE = 4'd6,
  parameter logic [3:0]  DEF_EXT  = 4'd3,
  parameter logic [3:0]  DEF_YEL  = 4'd2
) (
  input logic                     clock,
  input logic                     reset,
  phase_timer_scheduler_if.slave  bus
);

  logic [ParamW-1:0] base_q, base_d, ext_q, ext_d, yel_q, yel_d;
  state_e            state_q, state_d;
  logic [DurW-1:0]   cnt_q, cnt_d;
  logic [DurW-1:0]   dur;
  logic              restart_q, expired_q;
  logic              load, tick, run;

  assign run = (state_q == StRun);

  // Duration requested by interval_sel, from the current parameter registers.
  always_comb begin
    dur = {1'b0, base_q};
    unique case (bus.interval_sel)
      IntBase:   dur = {1'b0, base_q};
      IntExt:    dur = {1'b0, ext_q};
      IntYel:    dur = {1'b0, yel_q};
      IntBaseX2: dur = {base_q, 1'b0};
      default:   dur = {1'b0, base_q};
    endcase
  end

  // Parameter register writes; selector 3 restores every default.
  always_comb begin
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    if (bus.reprogram) begin
      unique case (bus.time_param_selector)
        SelBase: base_d = min_one(bus.time_value);
        SelExt:  ext_d  = min_one(bus.time_value);
        SelYel:  yel_d  = min_one(bus.time_value);
        default: begin
          base_d = DEF_BASE;
          ext_d  = DEF_EXT;
          yel_d  = DEF_YEL;
        end
      endcase
    end
  end

  // FSM next state and countdown; a reprogram overrides everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_timer) begin
          state_d = StRun;
          cnt_d   = dur;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (bus.start_timer) begin
          cnt_d = dur;
          load  = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DurW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (bus.start_timer) begin
          state_d = StRun;
          cnt_d   = dur;
          load    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.reprogram) begin
      state_d = StIdle;
      cnt_d   = '0;
      load    = 1'b0;
    end
  end

  // Prescaler is held at zero outside RUN and restarted on every load.
  sec_prescaler #(
    .ClkDiv (CLK_DIV)
  ) u_sec_prescaler (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (load | ~run),
    .en_i   (run),
    .tick_o (tick)
  );

  // State, countdown, parameter and pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      base_q    <= DEF_BASE;
      ext_q     <= DEF_EXT;
      yel_q     <= DEF_YEL;
      restart_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      ext_q     <= ext_d;
      yel_q     <= yel_d;
      restart_q <= bus.reprogram;
      // The DONE cycle is always reported, even if a reprogram arrives in it.
      expired_q <= (state_q == StDone);
    end
  end

  assign bus.busy    = run;
  assign bus.expired = expired_q;
  assign bus.restart = restart_q;
  assign bus.tick    = tick;

`ifdef TIMER_READBACK_EN
  assign bus.remaining = cnt_q;

  // Readback of the register addressed by the selector.
  always_comb begin
    bus.param_rdata = '0;
    unique case (bus.time_param_selector)
      SelBase: bus.param_rdata = base_q;
      SelExt:  bus.param_rdata = ext_q;
      SelYel:  bus.param_rdata = yel_q;
      default: bus.param_rdata = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_phase_timer_scheduler.sv
// Self-checking bench for phase_timer_scheduler: directed scenarios followed by
// random traffic, all compared cycle by cycle against an event-level model.
module tb_phase_timer_scheduler;

  localparam int C        = 4;
  localparam int DefBase  = 6;
  localparam int DefExt   = 3;
  localparam int DefYel   = 2;

  logic clock;
  logic reset;

  phase_timer_scheduler_if bus ();

  phase_timer_scheduler #(
    .CLK_DIV  (C),
    .DEF_BASE (4'(DefBase)),
    .DEF_EXT  (4'(DefExt)),
    .DEF_YEL  (4'(DefYel))
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Model: parameters, whether a countdown runs, its start edge and duration,
  // and the edge index at which an expired pulse is due.
  int p[3];
  bit m_run;
  int m_s, m_dur, m_pend;
  bit m_restart;
  int k = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, k);
  endtask

  task automatic model_reset();
    p[0] = DefBase; p[1] = DefExt; p[2] = DefYel;
    m_run = 1'b0; m_s = 0; m_dur = 0; m_pend = -1; m_restart = 1'b0;
  endtask

  // Apply the inputs sampled at edge k to the model.
  task automatic model_edge(input bit rp, input int sel, input int val, input bit st,
                            input int isel);
    bit done_now;
    done_now  = m_run && (k == m_s + m_dur * C);
    m_restart = rp;
    if (rp) begin
      m_run = 1'b0;
      if (sel == 3) begin
        p[0] = DefBase; p[1] = DefExt; p[2] = DefYel;
      end else begin
        p[sel] = (val == 0) ? 1 : val;
      end
    end else if (st) begin
      m_dur = (isel == 3) ? 2 * p[0] : p[isel];
      m_s   = k;
      m_run = 1'b1;
    end else if (done_now) begin
      m_run  = 1'b0;
      m_pend = k + 1;
    end
  endtask

  task automatic compare_outputs();
    check_eq("busy", int'(bus.busy), int'(m_run));
    check_eq("expired", int'(bus.expired), int'(m_pend == k));
    check_eq("restart", int'(bus.restart), int'(m_restart));
    check_eq("tick", int'(bus.tick), int'(m_run && ((k - m_s) % C == C - 1)));
`ifdef TIMER_READBACK_EN
    check_eq("remaining", int'(bus.remaining), m_run ? m_dur - (k - m_s) / C : 0);
    check_eq("param_rdata", int'(bus.param_rdata),
             (bus.time_param_selector == 2'd3) ? 0 : p[bus.time_param_selector]);
`endif
  endtask

  task automatic step(input bit rp, input logic [1:0] sel, input logic [3:0] val,
                      input bit st, input logic [1:0] isel);
    bus.reprogram           = rp;
    bus.time_param_selector = sel;
    bus.time_value          = val;
    bus.start_timer         = st;
    bus.interval_sel        = isel;
    @(posedge clock);
    k++;
    model_edge(rp, int'(sel), int'(val), st, int'(isel));
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
  endtask

  // Run idle until expired is seen (bounded) and check the latency from ks.
  task automatic wait_expired(input int ks, input int exp_lat, input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
      if (bus.expired) begin
        lat = k - ks;
        break;
      end
    end
    check_eq(tag, lat, exp_lat);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, int'(bus.busy), 0);
    check_eq({tag, "_expired"}, int'(bus.expired), 0);
    check_eq({tag, "_restart"}, int'(bus.restart), 0);
    check_eq({tag, "_tick"}, int'(bus.tick), 0);
`ifdef TIMER_READBACK_EN
    check_eq({tag, "_remaining"}, int'(bus.remaining), 0);
`endif
  endtask

  // Called #1 after a rising edge: assert reset between edges, check, release.
  task automatic reset_mid();
    bus.reprogram = 1'b0; bus.start_timer = 1'b0;
    #1 reset = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ks;
    reset = 1'b0;
    bus.reprogram = 1'b0; bus.time_param_selector = 2'd0; bus.time_value = 4'd0;
    bus.start_timer = 1'b0; bus.interval_sel = 2'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // Base interval with defaults: 6 s * 4 + 1.
    step(1'b0, 2'd0, 4'd0, 1'b1, 2'd0); ks = k;
    wait_expired(ks, 25, "lat_base");
    idle(2);

    // Yellow reprogrammed to 4: 4 * 4 + 1.
    step(1'b1, 2'd2, 4'd4, 1'b0, 2'd0);
    step(1'b0, 2'd0, 4'd0, 1'b1, 2'd2); ks = k;
    wait_expired(ks, 17, "lat_yel4");
    idle(2);

    // Base written as 0 is stored as 1; base x2 = 2 s.
    step(1'b1, 2'd0, 4'd0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 4'd0, 1'b1, 2'd3); ks = k;
    wait_expired(ks, 9, "lat_basex2_min");
    idle(2);

    // Restore defaults, start base, abort with reprogram at cycle 10.
    step(1'b1, 2'd3, 4'd9, 1'b0, 2'd0);
    step(1'b0, 2'd0, 4'd0, 1'b1, 2'd0);
    idle(9);
    step(1'b1, 2'd1, 4'd5, 1'b0, 2'd0);
    idle(40);

    // Start and reprogram together: start dropped, yellow becomes 7 s.
    step(1'b1, 2'd2, 4'd7, 1'b1, 2'd1);
    idle(3);
    step(1'b0, 2'd0, 4'd0, 1'b1, 2'd2); ks = k;
    wait_expired(ks, 29, "lat_after_collide");
    idle(2);

    // Retrigger with yellow at cycle 8, then reset mid-run.
    step(1'b1, 2'd3, 4'd0, 1'b0, 2'd0);
    step(1'b0, 2'd0, 4'd0, 1'b1, 2'd0);
    idle(7);
    step(1'b0, 2'd0, 4'd0, 1'b1, 2'd2);
    idle(4);
    reset_mid();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        @(posedge clock);
        k++;
        model_edge(1'b0, 0, 0, 1'b0, 0);
        bus.reprogram = 1'b0; bus.start_timer = 1'b0;
        reset_mid();
      end else begin
        step($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)),
             4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0,
             2'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
